regfile_mp_scoreboard: RTL
==========================

// Module: regfile_mp_scoreboard
// PURPOSE
//  Parametrised multi-port integer register file with per-register busy scoreboard
//  and a sequential clear engine. Sits in the decode/writeback boundary of the core:
//  decode reads operands and busy flags, issue marks destinations busy, writeback
//  ports write results and release busy. Array is cleared by an FSM, not by reset,
//  so it can map to latch/SRAM-style storage.
// PARAMETERS
//  XLEN      32   data width (32 or 64)
//  NREGS     32   number of architectural registers (power of 2, >=2)
//  NRD       2    number of read ports
//  NWR       2    number of write ports
//  ZERO_REG  1    1: register 0 hardwired to zero, never busy; 0: ordinary register
//  AW        $clog2(NREGS) address width (localparam, derived)
// PORTS
//  clk        in   1          clock, all state on rising edge
//  reset      in   1          asynchronous, active-high reset
//  rd_addr    in   NRD*AW     read addresses, port p at [p*AW +: AW]
//  rd_data    out  NRD*XLEN   read data, port p at [p*XLEN +: XLEN]
//  rd_busy    out  NRD        1: operand still pending a producer
//  wr_en      in   NWR        write enables
//  wr_addr    in   NWR*AW     write addresses
//  wr_data    in   NWR*XLEN   write data
//  iss_en     in   1          mark iss_addr busy (destination issued)
//  iss_addr   in   AW         destination being issued
//  clr_req    in   1          request full clear (pulse)
//  ready      out  1          1: array valid, FSM idle
// BEHAVIOUR
//  - Reset (async): FSM <= CLEAR, clr_cnt <= 0, all busy bits <= 0. Array itself not reset.
//    Outputs during/after reset: ready=0, rd_data=0, rd_busy=0.
//  - FSM states: CLEAR, IDLE.
//    CLEAR: each cycle writes 0 to reg[clr_cnt], clr_cnt++; at clr_cnt==NREGS-1 -> IDLE
//    next cycle. Clear takes exactly NREGS cycles after reset deasserts; ready=1 from
//    cycle NREGS onward. In CLEAR: wr_en, iss_en ignored, busy bits held 0.
//    IDLE: clr_req=1 -> CLEAR with clr_cnt=0, busy bits all cleared same edge;
//    writes/issues in that cycle dropped. clr_req in CLEAR ignored (no restart).
//  - Reads: combinational. While !ready, rd_data=0 and rd_busy=0.
//    Addr 0 with ZERO_REG=1 -> data 0, busy 0, regardless of writes.
//    Otherwise bypass: if any wr_en[w] && wr_addr[w]==rd_addr, return wr_data of the
//    highest-index matching port; else array contents.
//  - Writes (IDLE only): on clk edge each enabled port writes reg[wr_addr]; writes to
//    reg 0 dropped when ZERO_REG=1. Same address on several ports: highest index wins.
//  - Scoreboard (IDLE only), per register r, next busy[r]:
//    set   = iss_en && iss_addr==r
//    rel   = any wr_en[w] && wr_addr[w]==r
//    set has priority over rel (new producer issued the cycle old one retires).
//    reg 0 never busy when ZERO_REG=1.
//  - rd_busy[p] = busy[rd_addr] && !rel(rd_addr): result arriving this cycle is visible
//    through the bypass, so operand is not pending. iss_en same cycle does not affect
//    rd_busy until next cycle.
//  - Reset asserted mid-clear or mid-operation: immediate return to CLEAR, busy=0, ready=0;
//    clear sequence restarts from 0 after deassertion.
// STRUCTURE
//  - Shared package/header (rv_config.vh): XLEN default, NREGS default, FSM state encodings
//    (RF_ST_CLEAR, RF_ST_IDLE).
//  - One sub-module: rf_write_arbiter -- per-address priority select over NWR ports,
//    reused by both array write path and read bypass path (outputs hit + data).
//  - Top holds array, busy vector, clear FSM/counter and read muxes.
// TESTING
//  1. Release reset, count cycles: ready=0 for exactly NREGS(32) cycles, all reads = 0,
//     then ready=1 and every register reads 0.
//  2. Write x5=0xDEADBEEF on port0 and x5=0x12345678 on port1 same cycle -> read x5
//     same cycle = 0x12345678 (bypass), next cycle array = 0x12345678.
//  3. iss_en x7 -> rd_busy=1 on x7 next cycle; writeback x7=0xA5A5A5A5 -> rd_busy=0 and
//     data 0xA5A5A5A5 that cycle; busy bit cleared after edge.
//  4. Same cycle iss_en x9 and wr_en x9 -> x9 busy after edge; write x0=0xFFFFFFFF and
//     iss_en x0 -> x0 reads 0, never busy (ZERO_REG=1).
//  5. clr_req after writing x1..x31 non-zero with x3 busy -> ready=0 for 32 cycles, busy
//     cleared immediately, all regs 0 afterward; write attempted during CLEAR is lost.
//  6. Assert reset at clear cycle 10, hold 2 cycles -> clear restarts, ready after 32 more.
//     Repeat tests 2-3 with XLEN=64, NRD=4, NWR=3.

Source files
------------

// File: rtl/regfile_mp_scoreboard_pkg.sv
// Shared defaults and clear-FSM encodings for the multi-port register file.
package regfile_mp_scoreboard_pkg;

  localparam int RF_XLEN_DEF  = 32;
  localparam int RF_NREGS_DEF = 32;

  typedef enum logic {
    RF_ST_CLEAR = 1'b0,
    RF_ST_IDLE  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_mp_scoreboard_rf_write_arbiter.sv
// Priority select over all write ports for one address: the highest-index matching
// port wins. Used for the array write path and for each read-port bypass.
module rf_write_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NWR  = 2
) (
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [AW-1:0]       addr,
  output logic                hit,
  output logic [XLEN-1:0]     data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
        hit  = 1'b1;
        data = wr_data[w*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file with per-register busy scoreboard. The array has no
// reset; a sequential clear engine zeroes it after reset or on clr_req.
module regfile_mp_scoreboard
  import regfile_mp_scoreboard_pkg::*;
#(
  parameter int XLEN     = RF_XLEN_DEF,
  parameter int NREGS    = RF_NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                clr_req,
  output logic                ready
);

  rf_state_e                   state_q, state_d;
  logic [AW-1:0]               clr_cnt_q, clr_cnt_d;
  logic [XLEN-1:0]             regs [NREGS];
  logic [NREGS-1:0]            busy_q;
  logic [NREGS-1:0]            rel;
  logic [NREGS-1:0][XLEN-1:0]  wr_mdata;

  assign ready = (state_q == RF_ST_IDLE);

  // Per-register write match: drives both the array update and busy release.
  for (genvar r = 0; r < NREGS; r++) begin : g_wr
    rf_write_arbiter #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_arb (
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .addr    (AW'(r)),
      .hit     (rel[r]),
      .data    (wr_mdata[r])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RF_ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      RF_ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(NREGS - 1)) begin
          state_d   = RF_ST_IDLE;
          clr_cnt_d = '0;
        end
      end
      RF_ST_IDLE: begin
        if (clr_req) begin
          state_d   = RF_ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = RF_ST_CLEAR;
    endcase
  end

  // Storage is intentionally reset-less so it can map to latch/SRAM arrays.
  always_ff @(posedge clk) begin
    if (!ready) begin
      regs[clr_cnt_q] <= '0;
    end else if (!clr_req) begin
      for (int r = 0; r < NREGS; r++) begin
        if (rel[r] && !(ZERO_REG != 0 && r == 0)) regs[r] <= wr_mdata[r];
      end
    end
  end

  // A new issue beats a same-cycle writeback: the register has a fresh producer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else if (!ready || clr_req) begin
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (iss_en && (iss_addr == AW'(r))) busy_q[r] <= 1'b1;
        else if (rel[r])                    busy_q[r] <= 1'b0;
      end
      if (ZERO_REG != 0) busy_q[0] <= 1'b0;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   a;
    logic            hit;
    logic [XLEN-1:0] bdata;
    logic            zero;

    assign a    = rd_addr[p*AW +: AW];
    assign zero = (ZERO_REG != 0) && (a == '0);

    rf_write_arbiter #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_byp (
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .addr    (a),
      .hit     (hit),
      .data    (bdata)
    );

    assign rd_data[p*XLEN +: XLEN] = (!ready || zero) ? '0 : (hit ? bdata : regs[a]);
    assign rd_busy[p]              = ready && !zero && busy_q[a] && !hit;
  end

endmodule
